// File: rtl/rs_pp_credit_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rs_pp_credit_arbiter
// Purpose : Round-robin, credit-flow-controlled arbiter feeding one relay-station
//           pipeline link, with a flush (drain-to-idle) sequence.
// Revision: 1.0 - initial release
// ============================================================================
module rs_pp_credit_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = 2,
    parameter int CREDITS    = 8
) (
    input  logic                              clk,
    input  logic                              ap_rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic                              link_valid,
    output logic [ID_W+DATA_WIDTH-1:0]        link_data,
    input  logic                              credit_return,
    input  logic                              flush_req,
    output logic                              flush_done,
    output logic [$clog2(CREDITS+1)-1:0]      credit_avail,
    output logic                              err_credit
);

    localparam int c_cnt_w = $clog2(CREDITS + 1);
    localparam int c_ptr_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [c_cnt_w-1:0] c_full    = c_cnt_w'(CREDITS);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_last    = c_ptr_w'(NUM_REQ - 1);
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                       r_state;
    logic [c_cnt_w-1:0]           r_cnt;
    logic [c_ptr_w-1:0]           r_rr_ptr;
    logic                         r_link_valid;
    logic [ID_W+DATA_WIDTH-1:0]   r_link_data;
    logic                         r_flush_done;
    logic                         r_err;

    logic                         w_eligible;
    logic                         w_found;
    logic [NUM_REQ-1:0]           w_grant;
    logic [c_ptr_w-1:0]           w_gidx;
    logic [c_ptr_w:0]             w_scan;
    logic [DATA_WIDTH-1:0]        w_gdata;
    logic                         w_send;
    logic [c_cnt_w-1:0]           w_cnt_nxt;
    logic                         w_overflow;

    // A zero count blocks the grant even if a credit returns this same cycle.
    assign w_eligible = (r_state == S_RUN) && !flush_req && (r_cnt != '0);

    always_comb begin
        w_grant = '0;
        w_gidx  = '0;
        w_found = 1'b0;
        w_scan  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (c_ptr_w + 1)'(k);
            if (w_scan >= (c_ptr_w + 1)'(NUM_REQ)) begin
                w_scan = w_scan - (c_ptr_w + 1)'(NUM_REQ);
            end
            if (w_eligible && !w_found && req_valid[w_scan[c_ptr_w-1:0]]) begin
                w_found                          = 1'b1;
                w_gidx                           = w_scan[c_ptr_w-1:0];
                w_grant[w_scan[c_ptr_w-1:0]]     = 1'b1;
            end
        end
    end

    always_comb begin
        w_gdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_send = w_found;

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_overflow = 1'b0;
        if (w_send && !credit_return) begin
            w_cnt_nxt = r_cnt - c_cnt_one;
        end else if (credit_return && !w_send) begin
            if (r_cnt == c_full) begin
                w_overflow = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + c_cnt_one;
            end
        end
    end

    always_ff @(posedge clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state      <= S_RUN;
            r_cnt        <= c_full;
            r_rr_ptr     <= '0;
            r_link_valid <= 1'b0;
            r_link_data  <= '0;
            r_flush_done <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_link_valid <= w_send;
            if (w_overflow) begin
                r_err <= 1'b1;
            end
            if (w_send) begin
                r_link_data <= {ID_W'(w_gidx), w_gdata};
                r_rr_ptr    <= (w_gidx == c_last) ? '0 : (w_gidx + c_ptr_one);
            end
            case (r_state)
                S_RUN: begin
                    if (flush_req) begin
                        r_state <= S_DRAIN;
                    end
                end
                // Drain completes even if flush_req drops meanwhile.
                S_DRAIN: begin
                    if (w_cnt_nxt == c_full) begin
                        r_state      <= S_DONE;
                        r_flush_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!flush_req) begin
                        r_state      <= S_RUN;
                        r_flush_done <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_RUN;
                    r_flush_done <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready    = w_grant;
    assign link_valid   = r_link_valid;
    assign link_data    = r_link_data;
    assign flush_done   = r_flush_done;
    assign credit_avail = r_cnt;
    assign err_credit   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_rs_pp_credit_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_rs_pp_credit_arbiter
// Purpose : Directed self-checking bench for rs_pp_credit_arbiter (4 req, 8 credits).
// Revision: 1.0 - initial release
// ============================================================================
module tb_rs_pp_credit_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 32;
    localparam int ID_W       = 2;
    localparam int CREDITS    = 8;

    logic                          clk;
    logic                          ap_rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          link_valid;
    logic [ID_W+DATA_WIDTH-1:0]    link_data;
    logic                          credit_return;
    logic                          flush_req;
    logic                          flush_done;
    logic [3:0]                    credit_avail;
    logic                          err_credit;

    int n_chk = 0;
    int n_err = 0;

    rs_pp_credit_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .ID_W      (ID_W),
        .CREDITS   (CREDITS)
    ) dut (
        .clk          (clk),
        .ap_rst_n     (ap_rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .link_valid   (link_valid),
        .link_data    (link_data),
        .credit_return(credit_return),
        .flush_req    (flush_req),
        .flush_done   (flush_done),
        .credit_avail (credit_avail),
        .err_credit   (err_credit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset;
        @(negedge clk);
        ap_rst_n      = 1'b0;
        req_valid     = '0;
        req_data      = '0;
        credit_return = 1'b0;
        flush_req     = 1'b0;
        @(negedge clk);
        ap_rst_n = 1'b1;
    endtask

    task automatic test_reset;
        ap_rst_n      = 1'b0;
        req_valid     = '0;
        req_data      = '0;
        credit_return = 1'b0;
        flush_req     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (link_valid !== 1'b0) begin n_err++; $display("FAIL reset_link_valid got=%0h exp=0", link_valid); end
        n_chk++; if (link_data !== '0) begin n_err++; $display("FAIL reset_link_data got=%0h exp=0", link_data); end
        n_chk++; if (credit_avail !== 4'd8) begin n_err++; $display("FAIL reset_credit got=%0d exp=8", credit_avail); end
        n_chk++; if (flush_done !== 1'b0) begin n_err++; $display("FAIL reset_flush_done got=%0h exp=0", flush_done); end
        n_chk++; if (err_credit !== 1'b0) begin n_err++; $display("FAIL reset_err got=%0h exp=0", err_credit); end
        ap_rst_n = 1'b1;
    endtask

    // Requester 2 streams 10 words; each credit comes back 4 cycles after its send.
    task automatic test_single_stream;
        int          k;
        int          exp_cnt;
        int          obs_min;
        logic        prev_send;
        logic [31:0] prev_word;
        logic [3:0]  exp_rdy;
        do_reset();
        k = 0; exp_cnt = 8; obs_min = 8; prev_send = 1'b0; prev_word = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            n_chk++; if (link_valid !== prev_send) begin n_err++; $display("FAIL s1_link_valid c=%0d got=%0h exp=%0h", c, link_valid, prev_send); end
            if (prev_send) begin
                n_chk++; if (link_data !== {2'd2, prev_word}) begin n_err++; $display("FAIL s1_link_data c=%0d got=%0h exp=%0h", c, link_data, {2'd2, prev_word}); end
            end
            n_chk++; if (credit_avail !== 4'(exp_cnt)) begin n_err++; $display("FAIL s1_credit c=%0d got=%0d exp=%0d", c, credit_avail, exp_cnt); end
            if (int'(credit_avail) < obs_min) obs_min = int'(credit_avail);
            req_valid          = (k < 10) ? 4'b0100 : 4'b0000;
            req_data           = '0;
            req_data[64 +: 32] = 32'hA000_0000 + 32'(k);
            credit_return      = (c >= 4) && (c < 14);
            #1;
            exp_rdy = (k < 10) ? 4'b0100 : 4'b0000;
            n_chk++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL s1_ready c=%0d got=%0h exp=%0h", c, req_ready, exp_rdy); end
            prev_send = (k < 10);
            prev_word = 32'hA000_0000 + 32'(k);
            exp_cnt   = exp_cnt - (prev_send ? 1 : 0) + (credit_return ? 1 : 0);
            if (k < 10) k++;
        end
        @(negedge clk);
        req_valid = '0; credit_return = 1'b0;
        n_chk++; if (obs_min !== 4) begin n_err++; $display("FAIL s1_min_credit got=%0d exp=4", obs_min); end
        n_chk++; if (credit_avail !== 4'd8) begin n_err++; $display("FAIL s1_final_credit got=%0d exp=8", credit_avail); end
    endtask

    // All requesters valid, credits returned every cycle: strict 0,1,2,3 rotation.
    task automatic test_round_robin;
        int         prev_g;
        logic [3:0] exp_rdy;
        do_reset();
        prev_g = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (prev_g >= 0) begin
                n_chk++; if (link_valid !== 1'b1) begin n_err++; $display("FAIL rr_link_valid c=%0d got=%0h exp=1", c, link_valid); end
                n_chk++; if (link_data !== {2'(prev_g), 32'hB000_0000 + 32'(prev_g)}) begin n_err++; $display("FAIL rr_link_data c=%0d got=%0h exp id=%0d", c, link_data, prev_g); end
            end
            req_valid = 4'b1111;
            for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hB000_0000 + 32'(i);
            credit_return = 1'b1;
            #1;
            exp_rdy = 4'b0001 << (c % 4);
            n_chk++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_grant c=%0d got=%0h exp=%0h", c, req_ready, exp_rdy); end
            prev_g = c % 4;
        end
        @(negedge clk);
        req_valid = '0; credit_return = 1'b0;
        n_chk++; if (credit_avail !== 4'd8) begin n_err++; $display("FAIL rr_credit got=%0d exp=8", credit_avail); end
        n_chk++; if (err_credit !== 1'b0) begin n_err++; $display("FAIL rr_err got=%0h exp=0", err_credit); end
    endtask

    // No returns: exactly 8 words, then one returned credit releases one more.
    task automatic test_credit_exhaust;
        int sent;
        do_reset();
        sent = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            req_valid         = 4'b0001;
            req_data[31:0]    = 32'hC000_0000 + 32'(sent);
            credit_return     = 1'b0;
            #1;
            if (req_ready[0]) sent++;
        end
        n_chk++; if (sent !== 8) begin n_err++; $display("FAIL ex_sent got=%0d exp=8", sent); end
        n_chk++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL ex_ready_zero got=%0h exp=0", req_ready); end
        n_chk++; if (credit_avail !== 4'd0) begin n_err++; $display("FAIL ex_credit0 got=%0d exp=0", credit_avail); end
        @(negedge clk);
        credit_return = 1'b1;
        #1;
        n_chk++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL ex_ret_same_cycle got=%0h exp=0", req_ready); end
        @(negedge clk);
        credit_return = 1'b0;
        n_chk++; if (credit_avail !== 4'd1) begin n_err++; $display("FAIL ex_credit1 got=%0d exp=1", credit_avail); end
        #1;
        n_chk++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL ex_one_more got=%0h exp=1", req_ready); end
        @(negedge clk);
        n_chk++; if (link_valid !== 1'b1) begin n_err++; $display("FAIL ex_link_valid got=%0h exp=1", link_valid); end
        n_chk++; if (link_data !== {2'd0, 32'hC000_0008}) begin n_err++; $display("FAIL ex_link_data got=%0h exp=0c0000008", link_data); end
        #1;
        n_chk++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL ex_ready_again got=%0h exp=0", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_chk++; if (link_valid !== 1'b0) begin n_err++; $display("FAIL ex_link_idle got=%0h exp=0", link_valid); end
    endtask

    // Send+return cancel at 5; a return at full count sets the sticky error.
    task automatic test_credit_edges;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 4'b0010; credit_return = 1'b0;
        end
        @(negedge clk);
        n_chk++; if (credit_avail !== 4'd5) begin n_err++; $display("FAIL ce_credit5 got=%0d exp=5", credit_avail); end
        req_valid = 4'b0010; credit_return = 1'b1;
        #1;
        n_chk++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL ce_ready got=%0h exp=2", req_ready); end
        @(negedge clk);
        n_chk++; if (credit_avail !== 4'd5) begin n_err++; $display("FAIL ce_send_ret got=%0d exp=5", credit_avail); end
        req_valid = '0; credit_return = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (credit_avail !== 4'd8) begin n_err++; $display("FAIL ce_credit8 got=%0d exp=8", credit_avail); end
        n_chk++; if (err_credit !== 1'b0) begin n_err++; $display("FAIL ce_err_early got=%0h exp=0", err_credit); end
        @(negedge clk);
        credit_return = 1'b0;
        n_chk++; if (credit_avail !== 4'd8) begin n_err++; $display("FAIL ce_credit_hold got=%0d exp=8", credit_avail); end
        n_chk++; if (err_credit !== 1'b1) begin n_err++; $display("FAIL ce_err_set got=%0h exp=1", err_credit); end
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (err_credit !== 1'b1) begin n_err++; $display("FAIL ce_err_sticky got=%0h exp=1", err_credit); end
    endtask

    // Flush with 3 credits outstanding; grants resume at requester 3 afterwards.
    task automatic test_flush;
        do_reset();
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'hD000_0000 + 32'(i);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            req_valid = 4'b1111;
            #1;
            n_chk++; if (req_ready !== (4'b0001 << c)) begin n_err++; $display("FAIL fl_pre_grant c=%0d got=%0h", c, req_ready); end
        end
        @(negedge clk);
        n_chk++; if (credit_avail !== 4'd5) begin n_err++; $display("FAIL fl_credit5 got=%0d exp=5", credit_avail); end
        flush_req = 1'b1;
        #1;
        n_chk++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL fl_suppress got=%0h exp=0", req_ready); end
        for (int f = 1; f <= 4; f++) begin
            @(negedge clk);
            n_chk++; if (flush_done !== 1'b0) begin n_err++; $display("FAIL fl_done_early f=%0d got=%0h exp=0", f, flush_done); end
            credit_return = (f != 2);
            #1;
            n_chk++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL fl_drain_grant f=%0d got=%0h exp=0", f, req_ready); end
        end
        @(negedge clk);
        credit_return = 1'b0;
        n_chk++; if (flush_done !== 1'b1) begin n_err++; $display("FAIL fl_done got=%0h exp=1", flush_done); end
        n_chk++; if (credit_avail !== 4'd8) begin n_err++; $display("FAIL fl_credit8 got=%0d exp=8", credit_avail); end
        @(negedge clk);
        n_chk++; if (flush_done !== 1'b1) begin n_err++; $display("FAIL fl_done_hold got=%0h exp=1", flush_done); end
        flush_req = 1'b0;
        #1;
        n_chk++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL fl_done_grant got=%0h exp=0", req_ready); end
        @(negedge clk);
        n_chk++; if (flush_done !== 1'b0) begin n_err++; $display("FAIL fl_done_clear got=%0h exp=0", flush_done); end
        #1;
        n_chk++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL fl_resume got=%0h exp=8", req_ready); end
        @(negedge clk);
        req_valid = '0;
        n_chk++; if (link_data !== {2'd3, 32'hD000_0003} || link_valid !== 1'b1) begin n_err++; $display("FAIL fl_resume_link got=%0h exp=3d0000003", link_data); end
    endtask

    // Asynchronous reset mid-stream with 2 credits left and the error flag set.
    task automatic test_reset_midstream;
        do_reset();
        @(negedge clk);
        credit_return = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            credit_return = 1'b0;
            req_valid = 4'b0001;
            req_data[31:0] = 32'hE000_0000 + 32'(c);
        end
        @(negedge clk);
        n_chk++; if (credit_avail !== 4'd2) begin n_err++; $display("FAIL rm_credit2 got=%0d exp=2", credit_avail); end
        n_chk++; if (err_credit !== 1'b1) begin n_err++; $display("FAIL rm_err_pre got=%0h exp=1", err_credit); end
        n_chk++; if (link_valid !== 1'b1) begin n_err++; $display("FAIL rm_link_pre got=%0h exp=1", link_valid); end
        ap_rst_n = 1'b0;
        #1;
        n_chk++; if (link_valid !== 1'b0) begin n_err++; $display("FAIL rm_link_valid got=%0h exp=0", link_valid); end
        n_chk++; if (credit_avail !== 4'd8) begin n_err++; $display("FAIL rm_credit got=%0d exp=8", credit_avail); end
        n_chk++; if (err_credit !== 1'b0) begin n_err++; $display("FAIL rm_err got=%0h exp=0", err_credit); end
        n_chk++; if (link_data !== '0) begin n_err++; $display("FAIL rm_link_data got=%0h exp=0", link_data); end
        @(negedge clk);
        ap_rst_n = 1'b1;
        #1;
        n_chk++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rm_run_grant got=%0h exp=1", req_ready); end
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_stream();
        test_round_robin();
        test_credit_exhaust();
        test_credit_edges();
        test_flush();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
